// File: rtl/pwm_multi_if.sv
// pwm_multi_if: soft-core peripheral bus (sel/wstrb/addr/wdata/rdata) for pwm_multi.
// The CPU side uses the master modport and the peripheral uses the slave modport.
interface pwm_multi_if;
   logic        sel;
   logic        wstrb;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output wstrb, output addr, output wdata, input rdata);
   modport slave  (input sel, input wstrb, input addr, input wdata, output rdata);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: memory-mapped multi-channel PWM, shared period/prescaler, duty/period shadowed per period.
// Define PWM_CENTER_ALIGNED_EN to add the CTRL.CA centre-aligned (up/down counting) mode.
module pwm_multi #(
   parameter int WIDTH          = 8,
   parameter int CHANNELS       = 4,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   pwm_multi_if.slave          bus,
   output logic [CHANNELS-1:0] led
);
   localparam logic [3:0] A_CTRL     = 4'd0;
   localparam logic [3:0] A_PERIOD   = 4'd1;
   localparam logic [3:0] A_PRESCALE = 4'd2;
   localparam logic [3:0] A_STATUS   = 4'd3;

   logic                      w_wr;
   logic                      w_rd;
   logic                      r_en;
   logic                      r_inv;
   logic                      r_wrap;
   logic [WIDTH-1:0]          r_period_pend;
   logic [WIDTH-1:0]          r_period_act;
   logic [WIDTH-1:0]          r_cnt;
   logic [WIDTH-1:0]          w_cnt_next;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [PRESCALE_WIDTH-1:0] r_pcnt;
   logic                      w_tick;
   logic                      w_wrap_evt;
   logic                      w_load;
   logic [CHANNELS*WIDTH-1:0] w_duty_pend;
   logic [CHANNELS-1:0]       w_raw;
   logic [CHANNELS-1:0]       r_led;
   logic [31:0]               r_rdata;
   logic [31:0]               w_rd_data;

`ifdef PWM_CENTER_ALIGNED_EN
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   dir_t r_dir;
   dir_t w_dir_next;
   logic r_ca;
`endif

   assign w_wr = bus.sel & bus.wstrb;
   assign w_rd = bus.sel & ~bus.wstrb;

   // Control register; CA is only allowed to change while the counter is stopped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en  <= 1'b0;
         r_inv <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
         r_ca  <= 1'b0;
`endif
      end else if (w_wr && bus.addr == A_CTRL) begin
         r_en  <= bus.wdata[0];
         r_inv <= bus.wdata[1];
`ifdef PWM_CENTER_ALIGNED_EN
         if (!r_en) begin
            r_ca <= bus.wdata[2];
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period_pend <= '1;
         r_prescale    <= '0;
      end else if (w_wr) begin
         if (bus.addr == A_PERIOD) begin
            r_period_pend <= bus.wdata[WIDTH-1:0];
         end
         if (bus.addr == A_PRESCALE) begin
            r_prescale <= bus.wdata[PRESCALE_WIDTH-1:0];
         end
      end
   end

   // Prescaler; a PRESCALE lowered below the running count restarts it at 0
   assign w_tick = r_en && (r_pcnt == r_prescale);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (!r_en || r_pcnt >= r_prescale) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   always_comb begin
      w_wrap_evt = w_tick && (r_cnt >= r_period_act);
      w_cnt_next = r_cnt;
`ifdef PWM_CENTER_ALIGNED_EN
      w_dir_next = r_dir;
      if (r_ca) begin
         if (r_dir == DIR_UP) begin
            w_wrap_evt = w_tick && (r_cnt >= r_period_act) && (r_period_act <= WIDTH'(1));
         end else begin
            w_wrap_evt = w_tick && (r_cnt <= WIDTH'(1));
         end
      end
`endif
      if (!r_en || w_wrap_evt) begin
         w_cnt_next = '0;
`ifdef PWM_CENTER_ALIGNED_EN
         w_dir_next = DIR_UP;
`endif
      end else if (w_tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
         if (r_ca && (r_dir == DIR_DOWN || r_cnt >= r_period_act)) begin
            w_cnt_next = r_cnt - 1'b1;
            w_dir_next = DIR_DOWN;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
`else
         w_cnt_next = r_cnt + 1'b1;
`endif
      end
   end

   assign w_load = !r_en || w_wrap_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_period_act <= '1;
`ifdef PWM_CENTER_ALIGNED_EN
         r_dir        <= DIR_UP;
`endif
      end else begin
         r_cnt <= w_cnt_next;
`ifdef PWM_CENTER_ALIGNED_EN
         r_dir <= w_dir_next;
`endif
         if (w_load) begin
            r_period_act <= r_period_pend;
         end
      end
   end

   // A wrap on the same edge as a software clear keeps the flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrap <= 1'b0;
      end else if (w_wrap_evt) begin
         r_wrap <= 1'b1;
      end else if (w_wr && bus.addr == A_STATUS && bus.wdata[0]) begin
         r_wrap <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] r_duty_pend;
      logic [WIDTH-1:0] r_duty_act;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_duty_pend <= '0;
            r_duty_act  <= '0;
         end else begin
            if (w_wr && bus.addr == 4'(4 + gi)) begin
               r_duty_pend <= bus.wdata[WIDTH-1:0];
            end
            if (w_load) begin
               r_duty_act <= r_duty_pend;
            end
         end
      end

      assign w_duty_pend[gi*WIDTH +: WIDTH] = r_duty_pend;
      assign w_raw[gi]                      = (r_cnt < r_duty_act);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led <= '0;
      end else if (r_en) begin
         r_led <= w_raw ^ {CHANNELS{r_inv}};
      end else begin
         r_led <= {CHANNELS{r_inv}};
      end
   end

   assign led = r_led;

   always_comb begin
      w_rd_data = '0;
      case (bus.addr)
         A_CTRL: begin
            w_rd_data[0] = r_en;
            w_rd_data[1] = r_inv;
`ifdef PWM_CENTER_ALIGNED_EN
            w_rd_data[2] = r_ca;
`endif
         end
         A_PERIOD:   w_rd_data[WIDTH-1:0]          = r_period_pend;
         A_PRESCALE: w_rd_data[PRESCALE_WIDTH-1:0] = r_prescale;
         A_STATUS:   w_rd_data[0]                  = r_wrap;
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (bus.addr == 4'(4 + i)) begin
                  w_rd_data[WIDTH-1:0] = w_duty_pend[i*WIDTH +: WIDTH];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_rd) begin
         r_rdata <= w_rd_data;
      end
   end

   assign bus.rdata = r_rdata;
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Memory-mapped, multi-channel PWM peripheral on the RISC-V soft-core bus (sel/wstrb/wdata); next generation of the single-duty LED PWM driver.
- Each channel has its own duty register; all channels share one programmable period and a clock prescaler.
- Duty and period writes are double-buffered and take effect at the period boundary, so outputs never glitch.
- Adds register readback, output polarity control and a wrap status flag.

Parameters:
- WIDTH, 8, bit width of counter, period and duty registers (2..16).
- CHANNELS, 4, number of PWM outputs (1..8).
- PRESCALE_WIDTH, 16, bit width of the prescaler register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sel  in  1  peripheral selected for the current bus cycle.
- wstrb  in  1  1 = write, 0 = read (when sel=1).
- addr  in  4  word index into the register map.
- wdata  in  32  write data; LSBs used.
- rdata  out  32  read data.
- led  out  CHANNELS  PWM outputs, bit i = channel i.

Behaviour:
- Register map (word index):
  - 0 CTRL: bit0 EN, bit1 INV.
  - 1 PERIOD: WIDTH bits.
  - 2 PRESCALE: PRESCALE_WIDTH bits.
  - 3 STATUS: bit0 WRAP, sticky; write 1 clears it.
  - 4..4+CHANNELS-1 DUTY[i]: WIDTH bits.
  - Other indices: read 0; writes ignored.
- Reset values:
  - CTRL=0, PERIOD=2^WIDTH-1, PRESCALE=0, DUTY=0, STATUS=0.
  - Counters 0, active (shadow) regs equal pending regs, rdata=0, led=0.
- Write: sel&wstrb on a rising clk edge updates the pending register that same edge. Upper wdata bits are dropped.
- Read: sel&~wstrb latches rdata on the edge, valid the next cycle (1-cycle latency). rdata holds its value otherwise.
- Read values:
  - PERIOD and DUTY read back the pending value.
  - CTRL and PRESCALE read back the written value.
- Prescaler:
  - pcnt counts 0..PRESCALE; tick=1 when pcnt==PRESCALE, then pcnt returns to 0.
  - PRESCALE=0 gives a tick every clk.
- Main counter: advances on tick, counting 0..PERIOD_act. At cnt==PERIOD_act with tick:
  - cnt goes to 0.
  - WRAP is set.
  - All DUTY_act and PERIOD_act load from their pending registers.
- Output, per channel: raw = (cnt < DUTY_act[i]).
  - DUTY_act >= PERIOD_act+1 gives 100%; DUTY_act=0 gives 0%.
  - led[i] is registered: led[i] = raw XOR INV, 1 cycle after cnt.
- PERIOD=0: cnt stays at 0 and WRAP sets every tick. DUTY=0 gives constant low; DUTY>=1 gives constant high.
- EN=0:
  - pcnt and cnt held at 0.
  - Active registers load from pending every cycle.
  - led = {CHANNELS{INV}} (idle level).
- EN 0→1: counting starts from cnt=0 on the next edge using the current pending values.
- Simultaneous events:
  - A STATUS clear and a WRAP set in the same cycle: set wins.
  - A write to DUTY/PERIOD on the load edge: the old pending value is loaded; the new value applies next period.
- PRESCALE writes apply immediately. If pcnt > new PRESCALE, pcnt resets to 0 on the next edge.
- rst asserted mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- With the macro defined, CTRL bit2 CA selects center-aligned mode:
  - cnt counts up 0..PERIOD_act, then down PERIOD_act-1..1, and repeats.
  - Period length is 2*PERIOD_act ticks.
  - Shadow load and WRAP occur at the cnt==0 turnaround.
  - raw = (cnt < DUTY_act[i]), giving pulses symmetric about cnt=0.
  - CA changes apply only while EN=0.
- Without the macro: CTRL bit2 is ignored and reads 0; edge-aligned mode only; no up/down logic is synthesised.

Test Plan:
- Reset, then read CTRL/PERIOD/DUTY0 -> rdata 0, 255, 0 one cycle after each read; led=0.
- PERIOD=9, PRESCALE=0, DUTY0=3, DUTY1=0, DUTY2=10, EN=1 -> led0 high 3 of every 10 clks; led1 always 0; led2 always 1; WRAP set after the first 10 ticks.
- While running, write DUTY0=7 mid-period -> the current period keeps 3-high; the next period is 7-high, with no runt pulse.
- PRESCALE=2 with PERIOD=9, DUTY0=5 -> led0 high 15 clks out of 30; then set INV=1 -> led0 low 15 of 30; then EN=0 -> led all 1.
- Write STATUS=1 on the same edge WRAP sets -> WRAP reads 1; then write STATUS=1 -> reads 0. Assert rst mid-period -> led=0 and CTRL=0 immediately.
- With PWM_CENTER_ALIGNED_EN defined: CA=1, PERIOD=4, DUTY0=2, EN=1 -> cnt sequence 0,1,2,3,4,3,2,1,0; led0 high for cnt 0,1 only, i.e. 3 of every 8 ticks, centred on cnt=0.
